data_mem_responder: RTL and testbench

Responder end of the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake and returns read data or a write acknowledgement after a fixed access latency. It sits between the core's load/store path and the word storage, replacing the zero-latency combinational data memory so the core can be moved to a stalling, handshaked memory interface. Storage is an internal word array, cleared on reset.

---
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked data-memory responder.
// Accepts one load/store at a time, performs the access after a fixed
// latency and holds the response until the requester takes it.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          ready_q;
  logic          valid_q;
  logic          busy_q;
  logic [31:0]   mem_q [DEPTH];

  logic          acc_err_d;
  logic [AW-1:0] idx_d;

  // Decode the latched address: misaligned or beyond the array is an error.
  always_comb begin
    acc_err_d = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    idx_d     = addr_q[AW+1:2];
  end

  // Transaction FSM; storage and all outputs are updated here so every
  // output is a flop and request/response inputs never reach an output
  // combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // ready is high in IDLE, so a valid request is always taken here
          if (req_valid_i) begin
            wr_q    <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= S_WAIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            // Access happens on the edge that enters RESP; errors leave
            // storage untouched and report zero data.
            if (!acc_err_d && wr_q) mem_q[idx_d] <= wdata_q;
            rdata_q <= (!acc_err_d && !wr_q) ? mem_q[idx_d] : 32'd0;
            err_q   <= acc_err_d;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15) driven
// one at a time, checked against a word-array model of the storage.
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_ready [NI];
  wire         req_ready [NI];
  wire         rsp_valid [NI];
  wire  [31:0] rsp_rdata [NI];
  wire         rsp_err   [NI];
  wire         busy      [NI];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .busy_o(busy[0]));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .busy_o(busy[1]));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
    .clk_i(clk), .rst_i(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_write_i(req_write[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_rdata_o(rsp_rdata[2]),
    .rsp_err_o(rsp_err[2]), .busy_o(busy[2]));

  int          n_chk  = 0;
  int          n_fail = 0;
  int          acc_cyc;
  int          prev_acc_cyc;
  logic [31:0] mdl [NI][DEPTH];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Reference: a plain word array indexed by byte address / 4.
  function automatic void model_access(input int k, input logic w, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd,
                                       output logic e);
    e  = (a % 4 != 0) || ((a / 4) >= DEPTH);
    rd = 32'd0;
    if (!e && w) mdl[k][a / 4] = d;
    if (!e && !w) rd = mdl[k][a / 4];
  endfunction

  function automatic void model_clear(input int k);
    for (int i = 0; i < DEPTH; i++) mdl[k][i] = 32'd0;
  endfunction

  // One full transaction with optional response backpressure.
  task automatic txn(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    logic [31:0] erd, rd0;
    logic        ee, e0;
    int          edges;
    @(negedge clk);
    n_chk++;
    if (req_ready[k] !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready inst%0d got %b exp 1", k, req_ready[k]);
    end
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
    rsp_ready[k] = 1'b0;
    @(posedge clk); #1;
    prev_acc_cyc = acc_cyc; acc_cyc = cyc;
    req_valid[k] = 1'b0;
    edges = 0;
    while (rsp_valid[k] !== 1'b1 && edges < 40) begin
      n_chk++;
      if (req_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
        n_fail++; $display("FAIL wait_flags inst%0d ready=%b busy=%b exp 0/1", k, req_ready[k], busy[k]);
      end
      @(posedge clk); #1;
      edges++;
    end
    n_chk++;
    if (edges != lat_of(k)) begin
      n_fail++; $display("FAIL latency inst%0d got %0d edges exp %0d", k, edges, lat_of(k));
    end
    model_access(k, w, a, d, erd, ee);
    n_chk++;
    if (rsp_rdata[k] !== erd || rsp_err[k] !== ee) begin
      n_fail++; $display("FAIL rsp inst%0d addr=%h w=%b got rdata=%h err=%b exp rdata=%h err=%b",
                         k, a, w, rsp_rdata[k], rsp_err[k], erd, ee);
    end
    rd0 = rsp_rdata[k]; e0 = rsp_err[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid[k] = 1'b1; req_write[k] = 1'b1;
      req_addr[k] = {$urandom_range(0, DEPTH - 1), 2'b00}; req_wdata[k] = $urandom;
      @(posedge clk); #1;
      n_chk++;
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd0 || rsp_err[k] !== e0 || req_ready[k] !== 1'b0) begin
        n_fail++; $display("FAIL hold inst%0d valid=%b rdata=%h err=%b ready=%b exp 1/%h/%b/0",
                           k, rsp_valid[k], rsp_rdata[k], rsp_err[k], req_ready[k], rd0, e0);
      end
    end
    @(negedge clk);
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      n_fail++; $display("FAIL handshake inst%0d valid=%b ready=%b busy=%b exp 0/1/0",
                         k, rsp_valid[k], req_ready[k], busy[k]);
    end
  endtask

  task automatic test_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'd0 ||
        rsp_err[k] !== 1'b0 || busy[k] !== 1'b0) begin
      n_fail++; $display("FAIL reset inst%0d ready=%b valid=%b rdata=%h err=%b busy=%b exp 1/0/0/0/0",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k], busy[k]);
    end
    @(negedge clk);
    rst[k] = 1'b0;
    model_clear(k);
  endtask

  task automatic test_basic_load(input int k);
    txn(k, 1'b0, 32'h0000_0010, 32'd0, 0);
  endtask

  task automatic test_store_load(input int k);
    int first;
    txn(k, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 0);
    first = acc_cyc;
    txn(k, 1'b0, 32'h0000_0020, 32'd0, 0);
    n_chk++;
    if (acc_cyc - first != lat_of(k) + 2) begin
      n_fail++; $display("FAIL back_to_back inst%0d got %0d cycles exp %0d", k, acc_cyc - first, lat_of(k) + 2);
    end
  endtask

  task automatic test_misaligned(input int k);
    txn(k, 1'b1, 32'h0000_0022, 32'h1234_5678, 0);
    txn(k, 1'b0, 32'h0000_0020, 32'd0, 0);
  endtask

  task automatic test_range(input int k);
    txn(k, 1'b1, 32'h0000_01FC, 32'hA5A5_0F0F, 0);
    txn(k, 1'b0, 32'h0000_01FC, 32'd0, 0);
    txn(k, 1'b0, 32'h0000_0200, 32'd0, 0);
    txn(k, 1'b1, 32'h0000_0200, 32'h7777_7777, 0);
  endtask

  task automatic test_backpressure(input int k);
    txn(k, 1'b0, 32'h0000_0020, 32'd0, 5);
    txn(k, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 5);
  endtask

  task automatic test_reset_in_wait(input int k);
    txn(k, 1'b1, 32'h0000_0004, 32'h1111_2222, 0);
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = 1'b1;
    req_addr[k] = 32'h0000_0004; req_wdata[k] = 32'hCAFE_0001; rsp_ready[k] = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst[k] = 1'b0;
    model_clear(k);
    for (int i = 0; i < lat_of(k) + 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (rsp_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
        n_fail++; $display("FAIL abort inst%0d valid=%b busy=%b exp 0/0", k, rsp_valid[k], busy[k]);
      end
    end
    txn(k, 1'b0, 32'h0000_0004, 32'd0, 0);
  endtask

  task automatic test_random(input int k, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0:       a = {$urandom_range(DEPTH, 4 * DEPTH), 2'b00};
        1:       a = {$urandom_range(0, 7), 2'b00} | 32'($urandom_range(1, 3));
        2:       a = {$urandom_range(0, DEPTH - 1), 2'b00};
        default: a = {$urandom_range(0, 7), 2'b00};
      endcase
      txn(k, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    acc_cyc = 0; prev_acc_cyc = 0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      test_reset(k);
      test_basic_load(k);
      test_store_load(k);
      test_misaligned(k);
      test_range(k);
      test_backpressure(k);
      test_reset_in_wait(k);
      test_random(k, 20);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
